// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// data widths, ALU opcode, FSM state encoding and the shift helper.
package mul_seq_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;
  localparam int PROD_W = 2 * DATA_W;

  // Opcode of the external ALU that performs Y = A + B with carry-out
  localparam logic [2:0] ALU_OP_ADD = 3'b000;

  // Count value seen in the SHIFT state of the final iteration
  localparam logic [CNT_W-1:0] LAST_ITER = 4'd7;

  localparam logic [DATA_W-1:0] ZERO_D = {DATA_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ADD   = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // One logical right shift of the 17-bit {C,H,L} accumulator
  function automatic logic [PROD_W:0] shr17(input logic c,
                                            input logic [DATA_W-1:0] h,
                                            input logic [DATA_W-1:0] l);
    return {1'b0, c, h, l[DATA_W-1:1]};
  endfunction

endpackage

// File: rtl/mul_seq_fsm.sv
// Sequencer for mul_seq: owns the IDLE/ADD/SHIFT/DONE state and the
// iteration counter. skip_req is only ever high when the top is built
// with MUL_SEQ_ZERO_SKIP_EN; it sends an accepted request straight to DONE.
module mul_seq_fsm
  import mul_seq_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   start,
  input  logic   skip_req,
  output state_e state_r,
  output state_e nxt_state_s,
  output logic   accept_s,
  output logic   skip_s,
  output logic   busy_r,
  output logic   done_r
);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] nxt_cnt_s;

  // Next-state, counter update and request acceptance
  always_comb begin
    nxt_state_s = state_r;
    nxt_cnt_s   = cnt_r;
    accept_s    = 1'b0;
    skip_s      = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept_s  = 1'b1;
          nxt_cnt_s = 4'd0;
          if (skip_req) begin
            skip_s      = 1'b1;
            nxt_state_s = ST_DONE;
          end else begin
            nxt_state_s = ST_ADD;
          end
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
      ST_ADD: begin
        nxt_state_s = ST_SHIFT;
      end
      ST_SHIFT: begin
        nxt_cnt_s = cnt_r + 4'd1;
        if (cnt_r == LAST_ITER) begin
          nxt_state_s = ST_DONE;
        end else begin
          nxt_state_s = ST_ADD;
        end
      end
      default: begin
        nxt_state_s = ST_IDLE;
      end
    endcase
  end

  // State, counter and registered BUSY/DONE flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= nxt_state_s;
      cnt_r   <= nxt_cnt_s;
      busy_r  <= (nxt_state_s == ST_ADD) || (nxt_state_s == ST_SHIFT);
      done_r  <= (nxt_state_s == ST_DONE);
    end
  end

endmodule

// File: rtl/mul_seq.sv
// mul_seq: 8x8 unsigned shift-add multiplier using an external ALU for
// the additions. Eight ADD/SHIFT iterations, DONE pulses 17 cycles after
// START is accepted; PROD holds until the next result lands.
// Optional build macro MUL_SEQ_ZERO_SKIP_EN: a request with a zero operand
// completes in one cycle with PROD=0 instead of iterating.
module mul_seq
  import mul_seq_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [DATA_W-1:0] MCAND,
  input  logic [DATA_W-1:0] MPLIER,
  output logic              BUSY,
  output logic              DONE,
  output logic [PROD_W-1:0] PROD,
  output logic [DATA_W-1:0] ALU_A,
  output logic [DATA_W-1:0] ALU_B,
  output logic [2:0]        ALU_OP,
  input  logic [DATA_W-1:0] ALU_Y,
  input  logic              ALU_CO
);

  state_e state_r;
  state_e nxt_state_s;
  logic   accept_s;
  logic   skip_s;
  logic   skip_req_s;
  logic   busy_r;
  logic   done_r;

  logic [DATA_W-1:0] m_r, h_r, l_r;
  logic              c_r;
  logic [PROD_W-1:0] prod_r;
  logic [DATA_W-1:0] m_nx_s, h_nx_s, l_nx_s;
  logic              c_nx_s;
  logic [PROD_W-1:0] prod_nx_s;
  logic [PROD_W:0]   shift_s;

  logic [DATA_W-1:0] alu_a_r, alu_b_r;
  logic [DATA_W-1:0] alu_a_nx_s, alu_b_nx_s;

`ifdef MUL_SEQ_ZERO_SKIP_EN
  assign skip_req_s = (MCAND == ZERO_D) || (MPLIER == ZERO_D);
`else
  assign skip_req_s = 1'b0;
`endif

  mul_seq_fsm u_fsm (
    .clk         (CLK),
    .rst_n       (RST_N),
    .start       (START),
    .skip_req    (skip_req_s),
    .state_r     (state_r),
    .nxt_state_s (nxt_state_s),
    .accept_s    (accept_s),
    .skip_s      (skip_s),
    .busy_r      (busy_r),
    .done_r      (done_r)
  );

  // Datapath next values: load on accept, accumulate in ADD, shift in SHIFT
  always_comb begin
    m_nx_s    = m_r;
    h_nx_s    = h_r;
    l_nx_s    = l_r;
    c_nx_s    = c_r;
    prod_nx_s = prod_r;
    shift_s   = shr17(c_r, h_r, l_r);
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          m_nx_s = MCAND;
          l_nx_s = MPLIER;
          h_nx_s = ZERO_D;
          c_nx_s = 1'b0;
          if (skip_s) begin
            prod_nx_s = {PROD_W{1'b0}};
          end else begin
            prod_nx_s = prod_r;
          end
        end else begin
          m_nx_s = m_r;
        end
      end
      ST_ADD: begin
        h_nx_s = ALU_Y;
        c_nx_s = ALU_CO;
      end
      ST_SHIFT: begin
        {c_nx_s, h_nx_s, l_nx_s} = shift_s;
        // The final shift leaves the full product in {H,L}
        if (nxt_state_s == ST_DONE) begin
          prod_nx_s = shift_s[PROD_W-1:0];
        end else begin
          prod_nx_s = prod_r;
        end
      end
      default: begin
        m_nx_s = m_r;
      end
    endcase
  end

  // ALU operands are registered one cycle ahead so they are valid throughout ADD
  always_comb begin
    alu_a_nx_s = ZERO_D;
    alu_b_nx_s = ZERO_D;
    if (nxt_state_s == ST_ADD) begin
      alu_a_nx_s = h_nx_s;
      if (l_nx_s[0]) begin
        alu_b_nx_s = m_nx_s;
      end else begin
        alu_b_nx_s = ZERO_D;
      end
    end else begin
      alu_a_nx_s = ZERO_D;
      alu_b_nx_s = ZERO_D;
    end
  end

  // Datapath, product and ALU operand registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      m_r     <= ZERO_D;
      h_r     <= ZERO_D;
      l_r     <= ZERO_D;
      c_r     <= 1'b0;
      prod_r  <= {PROD_W{1'b0}};
      alu_a_r <= ZERO_D;
      alu_b_r <= ZERO_D;
    end else begin
      m_r     <= m_nx_s;
      h_r     <= h_nx_s;
      l_r     <= l_nx_s;
      c_r     <= c_nx_s;
      prod_r  <= prod_nx_s;
      alu_a_r <= alu_a_nx_s;
      alu_b_r <= alu_b_nx_s;
    end
  end

  assign BUSY   = busy_r;
  assign DONE   = done_r;
  assign PROD   = prod_r;
  assign ALU_A  = alu_a_r;
  assign ALU_B  = alu_b_r;
  assign ALU_OP = ALU_OP_ADD;

endmodule

// File: tb/tb_mul_seq.sv
// Testbench for mul_seq: behavioural ALU, scoreboard of expected products
// with acceptance time, monitor that checks each DONE against the queue.
module tb_mul_seq;

  logic        CLK;
  logic        RST_N;
  logic        START;
  logic [7:0]  MCAND;
  logic [7:0]  MPLIER;
  logic        BUSY;
  logic        DONE;
  logic [15:0] PROD;
  logic [7:0]  ALU_A;
  logic [7:0]  ALU_B;
  logic [2:0]  ALU_OP;
  logic [7:0]  ALU_Y;
  logic        ALU_CO;

  mul_seq dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .START  (START),
    .MCAND  (MCAND),
    .MPLIER (MPLIER),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .PROD   (PROD),
    .ALU_A  (ALU_A),
    .ALU_B  (ALU_B),
    .ALU_OP (ALU_OP),
    .ALU_Y  (ALU_Y),
    .ALU_CO (ALU_CO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural ALU: opcode 000 is an 8-bit add with carry-out
  logic [8:0] alu_sum;
  assign alu_sum = (ALU_OP == 3'b000) ? ({1'b0, ALU_A} + {1'b0, ALU_B}) : 9'd0;
  assign ALU_Y   = alu_sum[7:0];
  assign ALU_CO  = alu_sum[8];

  typedef struct {
    logic [15:0] prod;
    int          acc_edge;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          total;
  int          bad;
  int          edge_cnt;
  logic [15:0] held_prod;
  bit          co_seen;

  initial begin
    total     = 0;
    bad       = 0;
    edge_cnt  = 0;
    held_prod = 16'h0000;
    co_seen   = 1'b0;
  end

  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Monitor: every DONE must match the oldest outstanding request
  always @(negedge CLK) begin
    if (RST_N === 1'b1) begin
      if (BUSY === 1'b1 && ALU_CO === 1'b1) co_seen = 1'b1;
      if (DONE === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("prod", {16'h0, PROD}, {16'h0, e.prod});
          chk("latency", edge_cnt - e.acc_edge, e.lat);
          held_prod = e.prod;
        end
      end else begin
        chk("prod_hold", {16'h0, PROD}, {16'h0, held_prod});
      end
    end
  end

  // Issue one multiply; intr>0 pulses an ignored START at that cycle,
  // hold keeps START high (with 0x10 operands) throughout the busy window.
  task automatic do_mul(input logic [7:0] a, input logic [7:0] b,
                        input int intr, input bit hold);
    exp_t e;
    int   lat;
    lat = 17;
`ifdef MUL_SEQ_ZERO_SKIP_EN
    if (a == 8'h00 || b == 8'h00) lat = 1;
`endif
    START  = 1'b1;
    MCAND  = a;
    MPLIER = b;
    e.prod     = 16'(a) * 16'(b);
    e.acc_edge = edge_cnt;
    e.lat      = lat;
    sb.push_back(e);
    for (int i = 1; i <= lat; i++) begin
      @(negedge CLK);
      if (i < lat && i == intr) begin
        START = 1'b1; MCAND = 8'h99; MPLIER = 8'h99;
      end else if (i < lat && hold) begin
        START = 1'b1; MCAND = 8'h10; MPLIER = 8'h10;
      end else begin
        START = 1'b0; MCAND = 8'($urandom); MPLIER = 8'($urandom);
      end
      if (i < lat) chk("busy_window", {31'd0, BUSY}, 32'd1);
    end
    chk("busy_in_done", {31'd0, BUSY}, 32'd0);
  endtask

  task automatic idle(input int n);
    START = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
    chk({tag, "_done"}, {31'd0, DONE}, 32'd0);
    chk({tag, "_prod"}, {16'd0, PROD}, 32'd0);
    chk({tag, "_alu_a"}, {24'd0, ALU_A}, 32'd0);
    chk({tag, "_alu_b"}, {24'd0, ALU_B}, 32'd0);
    chk({tag, "_alu_op"}, {29'd0, ALU_OP}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] ra, rb;
    RST_N  = 1'b0;
    START  = 1'b0;
    MCAND  = 8'h00;
    MPLIER = 8'h00;
    repeat (3) @(negedge CLK);
    chk_reset_outputs("reset");
    RST_N = 1'b1;
    idle(2);

    do_mul(8'h0D, 8'h0B, -1, 1'b0);
    idle(2);
    co_seen = 1'b0;
    do_mul(8'hFF, 8'hFF, -1, 1'b0);
    chk("carry_seen", {31'd0, co_seen}, 32'd1);
    idle(1);
    do_mul(8'h12, 8'h34, 5, 1'b0);
    idle(3);
    do_mul(8'h02, 8'h03, -1, 1'b1);
    do_mul(8'h10, 8'h10, -1, 1'b0);
    idle(2);

    // Abort 0xAA*0x55 with reset at cycle 8; no result is expected
    START = 1'b1; MCAND = 8'hAA; MPLIER = 8'h55;
    @(negedge CLK);
    START = 1'b0;
    repeat (7) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    chk_reset_outputs("midreset");
    held_prod = 16'h0000;
    RST_N = 1'b1;
    idle(20);
    do_mul(8'h01, 8'h80, -1, 1'b0);
    idle(1);
    do_mul(8'h00, 8'h5A, -1, 1'b0);
    idle(1);

    for (int k = 0; k < 30; k++) begin
      ra = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      do_mul(ra, rb, $urandom_range(1, 15), 1'b0);
      idle($urandom_range(0, 3));
    end

    idle(5);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
